salida_pico_banco: RTL and testbench

- Clocked, parametrised output-port register bank for the PicoBlaze OUTPUT path; successor to the original combinational port decoder.
- Decodes id_port/write_s into NUM_CH channel registers of DATA_W bits.
- Shadowed channels (e.g. time/date/timer fields) are staged and committed atomically, so displays never show a torn value.
- Adds per-channel update pulses, optional auto-commit timeout and an unmapped-id flag.

---
 rtl/salida_pico_pkg.sv | 30 +++
 rtl/salida_pico_temporizador.sv | 37 +++
 rtl/salida_pico_banco.sv | 135 +++++++++++++
 tb/tb_salida_pico_banco.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/salida_pico_pkg.sv
// Shared definitions for the PicoBlaze output-port register bank:
// FSM encoding, default clock/timer channel map and symbolic port ids.
package salida_pico_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    // Channels 9 and 12 come out of reset at 1; channels 0..8 (time/date/timer) are shadowed.
    localparam logic [111:0] DEF_RST_VALS    = 112'h0001_0000_0100_0000_0000_0000_0000;
    localparam logic [13:0]  DEF_SHADOW_MASK = 14'h01FF;

    localparam logic [7:0] ID_SEG    = 8'h00;
    localparam logic [7:0] ID_MIN    = 8'h01;
    localparam logic [7:0] ID_HORA   = 8'h02;
    localparam logic [7:0] ID_DIA    = 8'h03;
    localparam logic [7:0] ID_MES    = 8'h04;
    localparam logic [7:0] ID_ANIO   = 8'h05;
    localparam logic [7:0] ID_TSEG   = 8'h06;
    localparam logic [7:0] ID_TMIN   = 8'h07;
    localparam logic [7:0] ID_THORA  = 8'h08;
    localparam logic [7:0] ID_BRILLO = 8'h09;
    localparam logic [7:0] ID_ALARMA = 8'h0A;
    localparam logic [7:0] ID_LED    = 8'h0B;
    localparam logic [7:0] ID_MODO   = 8'h0C;
    localparam logic [7:0] ID_AGARRE = 8'h0D;
    localparam logic [7:0] ID_COMMIT = 8'h0F;

endpackage

// File: rtl/salida_pico_temporizador.sv
// Auto-commit down-counter: loads AUTO_CYC-1, counts down while enabled,
// and flags expiry at zero. AUTO_CYC = 0 keeps expire_o permanently low.
module salida_pico_temporizador #(
    parameter int AUTO_CYC = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CNT_W = (AUTO_CYC > 1) ? $clog2(AUTO_CYC) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'((AUTO_CYC > 0) ? AUTO_CYC - 1 : 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (AUTO_CYC != 0) && (cnt_q == '0);

endmodule

// File: rtl/salida_pico_banco.sv
// Clocked PicoBlaze output-port bank with shadowed channels that commit atomically,
// per-channel update pulses, optional auto-commit and an unmapped-id flag.
module salida_pico_banco
    import salida_pico_pkg::*;
#(
    parameter int                       DATA_W      = 8,
    parameter int                       NUM_CH      = 14,
    parameter logic [7:0]               BASE_ID     = 8'h00,
    parameter logic [7:0]               COMMIT_ID   = 8'h0F,
    parameter logic [NUM_CH-1:0]        SHADOW_MASK = DEF_SHADOW_MASK,
    parameter logic [NUM_CH*DATA_W-1:0] RST_VALS    = DEF_RST_VALS,
    parameter int                       AUTO_CYC    = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 id_port,
    input  logic [DATA_W-1:0]          pico_out,
    input  logic                       write_s,
    output logic [NUM_CH*DATA_W-1:0]   port_data,
    output logic [NUM_CH-1:0]          port_upd,
    output logic                       pend,
    output logic                       commit_done,
    output logic                       id_miss
);

    state_t                     state_q, state_d;
    logic [NUM_CH*DATA_W-1:0]   data_q, data_d;
    logic [NUM_CH*DATA_W-1:0]   shadow_q, shadow_d;
    logic [NUM_CH-1:0]          dirty_q, dirty_d;
    logic [NUM_CH-1:0]          upd_q, upd_d;
    logic                       done_q, done_d;
    logic                       miss_q, miss_d;

    logic [7:0]         idx;
    logic [NUM_CH-1:0]  hit;
    logic               isCmd, isCh, shadowWr, expire, timerExp, doCommit, doAbort;

    // Index wraps in 8 bits, so ids below BASE_ID land far above NUM_CH and read as unmapped.
    always_comb begin
        idx   = id_port - BASE_ID;
        isCmd = write_s && (id_port == COMMIT_ID);
        isCh  = write_s && !isCmd && (32'(idx) < NUM_CH);
        hit   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            hit[k] = isCh && (idx == 8'(k));
        end
        shadowWr = |(hit & SHADOW_MASK);
        expire   = timerExp && (state_q == PENDING) && !shadowWr;
        doCommit = (isCmd && pico_out[0]) || expire;
        doAbort  = isCmd && !pico_out[0];
    end

    salida_pico_temporizador #(
        .AUTO_CYC (AUTO_CYC)
    ) u_temporizador (
        .clk      (clk),
        .reset    (reset),
        .load_i   (shadowWr),
        .en_i     (state_q == PENDING),
        .expire_o (timerExp)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (shadowWr) state_d = PENDING;
            PENDING: if (isCmd || expire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        data_d   = data_q;
        shadow_d = shadow_q;
        dirty_d  = dirty_q;
        upd_d    = '0;
        done_d   = isCmd || expire;
        miss_d   = write_s && !isCmd && !isCh;
        for (int k = 0; k < NUM_CH; k++) begin
            if (hit[k]) begin
                if (SHADOW_MASK[k]) begin
                    shadow_d[k*DATA_W +: DATA_W] = pico_out;
                    dirty_d[k] = 1'b1;
                end else begin
                    data_d[k*DATA_W +: DATA_W] = pico_out;
                    upd_d[k] = 1'b1;
                end
            end
        end
        if (doCommit) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (dirty_q[k]) begin
                    data_d[k*DATA_W +: DATA_W] = shadow_q[k*DATA_W +: DATA_W];
                    upd_d[k] = 1'b1;
                end
            end
            dirty_d = '0;
        end
        if (doAbort) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (SHADOW_MASK[k]) begin
                    shadow_d[k*DATA_W +: DATA_W] = data_q[k*DATA_W +: DATA_W];
                end
            end
            dirty_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            data_q   <= RST_VALS;
            shadow_q <= RST_VALS;
            dirty_q  <= '0;
            upd_q    <= '0;
            done_q   <= 1'b0;
            miss_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            shadow_q <= shadow_d;
            dirty_q  <= dirty_d;
            upd_q    <= upd_d;
            done_q   <= done_d;
            miss_q   <= miss_d;
        end
    end

    assign port_data   = data_q;
    assign port_upd    = upd_q;
    assign pend        = (state_q == PENDING);
    assign commit_done = done_q;
    assign id_miss     = miss_q;

endmodule

// File: tb/tb_salida_pico_banco.sv
// Directed bench: dutA uses the default map without auto-commit, dutB enables AUTO_CYC = 4.
module tb_salida_pico_banco;

    localparam logic [111:0] RST = 112'h0001_0000_0100_0000_0000_0000_0000;

    logic         clk;
    logic         reset;
    logic [7:0]   id_port;
    logic [7:0]   pico_out;
    logic         write_s;

    logic [111:0] dataA, dataB;
    logic [13:0]  updA, updB;
    logic         pendA, pendB, doneA, doneB, missA, missB;

    logic [111:0] expA;
    int           checks;
    int           errors;

    salida_pico_banco dutA (
        .clk         (clk),
        .reset       (reset),
        .id_port     (id_port),
        .pico_out    (pico_out),
        .write_s     (write_s),
        .port_data   (dataA),
        .port_upd    (updA),
        .pend        (pendA),
        .commit_done (doneA),
        .id_miss     (missA)
    );

    salida_pico_banco #(
        .AUTO_CYC (4)
    ) dutB (
        .clk         (clk),
        .reset       (reset),
        .id_port     (id_port),
        .pico_out    (pico_out),
        .write_s     (write_s),
        .port_data   (dataB),
        .port_upd    (updB),
        .pend        (pendB),
        .commit_done (doneB),
        .id_miss     (missB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the write is sampled at the next rising edge and
    // the task returns at the following falling edge with the results visible.
    task automatic applyStimulus(input logic [7:0] id, input logic [7:0] d);
        id_port  = id;
        pico_out = d;
        write_s  = 1'b1;
        @(negedge clk);
        write_s  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] ch(input logic [111:0] v, input int k);
        return v[k*8 +: 8];
    endfunction

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        write_s  = 1'b0;
        id_port  = 8'h00;
        pico_out = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        expA  = RST;

        checkOutput("rst_data", dataA, RST);
        checkOutput("rst_dataB", dataB, RST);
        checkOutput("rst_pend", pendA, 1'b0);
        checkOutput("rst_upd", updA, 14'h0000);
        checkOutput("rst_pulses", {doneA, missA}, 2'b00);

        // Direct write to channel 11
        applyStimulus(8'h0B, 8'h5A);
        expA[88 +: 8] = 8'h5A;
        checkOutput("direct_data", dataA, expA);
        checkOutput("direct_upd", updA, 14'h0800);
        idle(1);
        checkOutput("direct_upd_end", updA, 14'h0000);

        // Direct rewrite with the same value still pulses
        applyStimulus(8'h0B, 8'h5A);
        checkOutput("direct_same_upd", updA, 14'h0800);

        // Stage three shadowed channels then commit atomically
        applyStimulus(8'h00, 8'h30);
        checkOutput("stage0_pend", pendA, 1'b1);
        applyStimulus(8'h01, 8'h59);
        applyStimulus(8'h02, 8'h23);
        checkOutput("stage_data", dataA, expA);
        checkOutput("stage_upd", updA, 14'h0000);
        checkOutput("stage_pend", pendA, 1'b1);
        applyStimulus(8'h0F, 8'h01);
        expA[0 +: 24] = 24'h23_59_30;
        checkOutput("commit_data", dataA, expA);
        checkOutput("commit_upd", updA, 14'h0007);
        checkOutput("commit_done", doneA, 1'b1);
        checkOutput("commit_pend", pendA, 1'b0);
        idle(1);
        checkOutput("commit_done_end", {doneA, updA}, 15'h0000);

        // Abort discards the staged value
        applyStimulus(8'h03, 8'h15);
        checkOutput("abort_stage_pend", pendA, 1'b1);
        applyStimulus(8'h0F, 8'h00);
        checkOutput("abort_data", dataA, expA);
        checkOutput("abort_upd", updA, 14'h0000);
        checkOutput("abort_done", doneA, 1'b1);
        checkOutput("abort_pend", pendA, 1'b0);
        applyStimulus(8'h0F, 8'h01);
        checkOutput("idle_commit_data", dataA, expA);
        checkOutput("idle_commit_upd", updA, 14'h0000);
        checkOutput("idle_commit_done", doneA, 1'b1);
        checkOutput("idle_commit_pend", pendA, 1'b0);

        // Unmapped ids and the top boundary of the channel range
        applyStimulus(8'h20, 8'hAA);
        checkOutput("miss20", missA, 1'b1);
        checkOutput("miss20_data", dataA, expA);
        checkOutput("miss20_upd", {updA, pendA, doneA}, 16'h0000);
        idle(1);
        checkOutput("miss_end", missA, 1'b0);
        applyStimulus(8'h0E, 8'hBB);
        checkOutput("miss0E", missA, 1'b1);
        checkOutput("miss0E_data", dataA, expA);
        applyStimulus(8'h0D, 8'hC3);
        expA[104 +: 8] = 8'hC3;
        checkOutput("ch13_miss", missA, 1'b0);
        checkOutput("ch13_data", dataA, expA);
        checkOutput("ch13_upd", updA, 14'h2000);

        // Reset while pending drops staged data
        applyStimulus(8'h04, 8'h77);
        checkOutput("rstpend_pend", pendA, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        expA  = RST;
        checkOutput("rstpend_data", dataA, RST);
        checkOutput("rstpend_pulses", {updA, pendA, doneA, missA}, 17'h0);
        applyStimulus(8'h0F, 8'h01);
        checkOutput("rstpend_commit_data", dataA, RST);
        checkOutput("rstpend_commit_upd", updA, 14'h0000);

        // Auto-commit on dutB: commit lands on the fourth edge after the write
        applyStimulus(8'h06, 8'h10);
        for (int i = 1; i <= 3; i++) begin
            idle(1);
            checkOutput($sformatf("auto_wait%0d", i), {ch(dataB, 6), pendB, doneB}, {8'h00, 2'b10});
        end
        idle(1);
        checkOutput("auto_data", ch(dataB, 6), 8'h10);
        checkOutput("auto_upd", updB, 14'h0040);
        checkOutput("auto_done", doneB, 1'b1);
        checkOutput("auto_pend", pendB, 1'b0);

        // A rewrite three edges later pushes the commit out by four from the rewrite
        applyStimulus(8'h06, 8'h20);
        idle(2);
        applyStimulus(8'h06, 8'h21);
        idle(1);
        checkOutput("auto_delay_old", {ch(dataB, 6), updB, pendB}, {8'h10, 14'h0000, 1'b1});
        idle(2);
        checkOutput("auto_delay_wait", {ch(dataB, 6), pendB}, {8'h10, 1'b1});
        idle(1);
        checkOutput("auto_delay_data", ch(dataB, 6), 8'h21);
        checkOutput("auto_delay_upd", {updB, doneB, pendB}, {14'h0040, 2'b10});

        // A write on the expiry edge wins and reloads the timer
        applyStimulus(8'h07, 8'h33);
        idle(3);
        applyStimulus(8'h07, 8'h34);
        checkOutput("expiry_write", {ch(dataB, 7), updB, doneB, pendB}, {8'h00, 14'h0000, 2'b01});
        idle(3);
        checkOutput("expiry_wait", {ch(dataB, 7), pendB}, {8'h00, 1'b1});
        idle(1);
        checkOutput("expiry_data", ch(dataB, 7), 8'h34);
        checkOutput("expiry_upd", {updB, doneB, pendB}, {14'h0080, 2'b10});

        // Without auto-commit dutA is still holding its staged channels
        checkOutput("noauto_pend", pendA, 1'b1);
        checkOutput("noauto_data", dataA, RST);
        applyStimulus(8'h0F, 8'h01);
        expA[48 +: 16] = 16'h34_21;
        checkOutput("noauto_commit_data", dataA, expA);
        checkOutput("noauto_commit_upd", updA, 14'h00C0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
